// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [3:0]  byteEnable,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_div;
  logic [1:0]    r_ctrl;
  logic [1:0]    r_state;
  logic [15:0]   r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  logic       w_wr;
  logic       w_push;
  logic       w_pop;
  logic       w_accept;
  logic       w_full;
  logic       w_empty;
  logic       w_busy;
  logic       w_bit_end;
  logic [1:0] w_off;
  logic [4:0] w_count5;
  logic       w_unused;

  assign sel       = (ALUResult[31:4] == BASE_ADDR[31:4]);
  assign w_off     = ALUResult[3:2];
  assign w_wr      = MemWrite & sel;
  assign w_push    = w_wr & (w_off == 2'd0) & byteEnable[0];
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_bit_end = (r_timer == 16'd0);
  assign w_count5  = 5'(r_count);
  assign w_unused  = &{1'b0, ALUResult[1:0], WriteData[31:16], byteEnable[3:2]};

  // Pops happen from IDLE or on the last clock of STOP, giving gapless frames.
  assign w_pop    = r_ctrl[0] & ~w_empty &
                    ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
  // A push into a full FIFO survives when the head leaves on the same edge.
  assign w_accept = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_accept & ~w_pop)      r_count <= r_count + CW'(1);
      else if (~w_accept & w_pop) r_count <= r_count - CW'(1);
      if (w_wr & (w_off == 2'd1) & byteEnable[0] & WriteData[3]) r_ovf <= 1'b0;
      else if (w_push & ~w_accept)                              r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div  <= DEFAULT_DIV;
      r_ctrl <= 2'b01;
    end else if (w_wr) begin
      if (w_off == 2'd2) begin
        if (byteEnable[0]) r_div[7:0]  <= WriteData[7:0];
        if (byteEnable[1]) r_div[15:8] <= WriteData[15:8];
      end
      if ((w_off == 2'd3) && byteEnable[0]) r_ctrl <= WriteData[1:0];
    end
  end

  // The timer reloads from DIV at every bit boundary, so DIV edits apply next bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_timer <= r_div;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer   <= r_div;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= r_div;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_timer <= r_div;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign irq = r_ctrl[1] & w_empty & ~w_busy;

  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (w_off)
        2'd1:    ReadData = {23'd0, w_count5, r_ovf, w_empty, w_full, w_busy};
        2'd2:    ReadData = {16'd0, r_div};
        2'd3:    ReadData = {30'd0, r_ctrl};
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE   = 32'h0000_FF00;
  localparam logic [31:0] A_TX   = BASE;
  localparam logic [31:0] A_ST   = BASE + 32'd4;
  localparam logic [31:0] A_DIV  = BASE + 32'd8;
  localparam logic [31:0] A_CTRL = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [3:0]  byteEnable = '0;
  logic [31:0] ReadData;
  logic        sel;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] m_div;
  logic [1:0]  m_ctrl;
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_push[$];

  mmio_uart_tx dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .byteEnable(byteEnable), .ReadData(ReadData),
    .sel(sel), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ALUResult = a; WriteData = d; byteEnable = be; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; byteEnable = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    MemWrite = 1'b0; ALUResult = a;
    #1;
    d = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_div = 16'd433; m_ctrl = 2'b01;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(A_ST, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 00000004", d); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL reset_sel: got %b expected 1", sel); end
    bus_read(A_DIV, d);
    checks++; if (d !== 32'd433) begin errors++; $display("FAIL reset_div: got %0d expected 433", d); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL reset_ctrl: got %h expected 1", d); end
    bus_read(A_TX, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_txdata_read: got %h expected 0", d); end
    @(negedge clk);
  endtask

  // Frames are predicted from the 8N1 rule: bit slot k of byte f is (k/(div+1)) of 10 slots.
  task automatic run_frames(input int div, input bit kick, input int pre);
    logic [7:0]  exp_q[$];
    logic [31:0] d;
    logic [31:0] w;
    logic [31:0] exp_st;
    logic        exp_tx;
    logic        busy;
    logic        exp_irq;
    int n, np, len, total, off, pushes, pops, cnt, k, f, b;
    bus_write(A_DIV, 32'(div), 4'b0011);
    m_div = 16'(div);
    exp_q = m_fifo;
    foreach (m_push[i]) exp_q.push_back(m_push[i]);
    n = exp_q.size(); np = m_push.size();
    len = 10 * (div + 1); off = kick ? 1 : 0;
    total = 2 + n * len + 3;
    for (int r = 0; r < total; r++) begin
      MemWrite = 1'b0;
      k = r - 2;
      exp_tx = 1'b1;
      if (k >= 0 && k < n * len) begin
        f = k / len; b = (k % len) / (div + 1);
        if (b == 0)      exp_tx = 1'b0;
        else if (b == 9) exp_tx = 1'b1;
        else             exp_tx = exp_q[f][b-1];
      end
      checks++; if (tx !== exp_tx) begin errors++; $display("FAIL frame_tx: div=%0d r=%0d got %b expected %b", div, r, tx, exp_tx); end
      pushes = r - off;
      if (pushes < 0) pushes = 0;
      if (pushes > np) pushes = np;
      pops = (r < 2) ? 0 : ((r - 2) / len + 1);
      if (pops > n) pops = n;
      cnt = pre + pushes - pops;
      busy = (r >= 2) && (r < 2 + n * len);
      exp_st = {23'd0, 5'(cnt), 1'b0, (cnt == 0), (cnt == 8), busy};
      bus_read(A_ST, d);
      checks++; if (d !== exp_st) begin errors++; $display("FAIL frame_status: div=%0d r=%0d got %h expected %h", div, r, d, exp_st); end
      exp_irq = m_ctrl[1] & (cnt == 0) & ~busy;
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL frame_irq: r=%0d got %b expected %b", r, irq, exp_irq); end
      if (kick && r == 0) begin
        ALUResult = A_CTRL; WriteData = {30'd0, m_ctrl[1], 1'b1}; byteEnable = 4'b0001; MemWrite = 1'b1;
      end else if (r - off >= 0 && r - off < np) begin
        w = $urandom(); w[7:0] = m_push[r-off];
        ALUResult = A_TX; WriteData = w; byteEnable = 4'b0001 | 4'($urandom_range(0, 15)); MemWrite = 1'b1;
      end
      @(negedge clk);
    end
    MemWrite = 1'b0;
    if (kick) m_ctrl[0] = 1'b1;
    m_fifo.delete();
    m_push.delete();
  endtask

  task automatic test_single_frame();
    m_push.push_back(8'hA5);
    run_frames(3, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    m_push.push_back(8'h55);
    m_push.push_back(8'h0F);
    run_frames(0, 1'b0, 0);
  endtask

  task automatic test_random_frames();
    int np;
    for (int t = 0; t < 6; t++) begin
      m_ctrl = {1'($urandom_range(0, 1)), 1'b1};
      bus_write(A_CTRL, {30'd0, m_ctrl}, 4'b0001);
      np = $urandom_range(1, 4);
      for (int i = 0; i < np; i++) m_push.push_back(8'($urandom()));
      run_frames($urandom_range(0, 4), 1'b0, 0);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  v;
    m_ctrl = 2'b00;
    bus_write(A_CTRL, 32'd0, 4'b0001);
    for (int i = 0; i < 9; i++) begin
      v = 8'($urandom());
      if (i < 8) m_fifo.push_back(v);
      bus_write(A_TX, {24'd0, v}, 4'b0001);
    end
    bus_read(A_ST, d);
    checks++; if (d !== 32'h8A) begin errors++; $display("FAIL overflow_status: got %h expected 0000008a", d); end
    bus_write(A_ST, 32'h8, 4'b1110);
    bus_read(A_ST, d);
    checks++; if (d !== 32'h8A) begin errors++; $display("FAIL overflow_clear_lane: got %h expected 0000008a", d); end
    bus_write(A_ST, 32'h8, 4'b0001);
    bus_read(A_ST, d);
    checks++; if (d !== 32'h82) begin errors++; $display("FAIL overflow_clear: got %h expected 00000082", d); end
    run_frames($urandom_range(0, 2), 1'b1, 8);
  endtask

  task automatic test_lanes_decode();
    logic [31:0] d;
    logic [31:0] v;
    v = $urandom();
    bus_write(A_DIV, v, 4'b1111); m_div = v[15:0];
    bus_read(A_DIV, d);
    checks++; if (d !== {16'd0, m_div}) begin errors++; $display("FAIL div_full: got %h expected %h", d, {16'd0, m_div}); end
    bus_write(A_DIV, 32'h0000_1200, 4'b0010); m_div[15:8] = 8'h12;
    bus_read(A_DIV, d);
    checks++; if (d !== {16'd0, m_div}) begin errors++; $display("FAIL div_lane1: got %h expected %h", d, {16'd0, m_div}); end
    v = $urandom();
    bus_write(A_DIV, v, 4'b0001); m_div[7:0] = v[7:0];
    bus_read(A_DIV + 32'd3, d);
    checks++; if (d !== {16'd0, m_div}) begin errors++; $display("FAIL div_lane0: got %h expected %h", d, {16'd0, m_div}); end
    bus_write(A_CTRL, 32'hFFFF_FFFE, 4'b1110);
    bus_read(A_CTRL, d);
    checks++; if (d !== {30'd0, m_ctrl}) begin errors++; $display("FAIL ctrl_upper_lanes: got %h expected %h", d, {30'd0, m_ctrl}); end
    bus_write(BASE + 32'h10, $urandom(), 4'b1111);
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL decode_sel: got %b expected 0", sel); end
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL decode_rdata: got %h expected 0", ReadData); end
    bus_write(A_TX, $urandom(), 4'b1110);
    bus_read(A_DIV, d);
    checks++; if (d !== {16'd0, m_div}) begin errors++; $display("FAIL decode_div: got %h expected %h", d, {16'd0, m_div}); end
    bus_read(A_ST, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL decode_status: got %h expected 00000004", d); end
  endtask

  task automatic test_irq_reset();
    logic [31:0] d;
    logic [7:0]  v;
    bus_write(A_DIV, 32'd3, 4'b0011); m_div = 16'd3;
    bus_write(A_CTRL, 32'd3, 4'b0001); m_ctrl = 2'b11;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b expected 1", irq); end
    bus_write(A_TX, 32'h3C, 4'b0001);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_push: got %b expected 0", irq); end
    repeat (40) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_in_stop: got %b expected 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_stop: got %b expected 1", irq); end
    v = 8'($urandom());
    bus_write(A_TX, {24'd0, v}, 4'b0001);
    bus_write(A_TX, 32'($urandom()), 4'b0001);
    repeat (6) @(negedge clk);
    checks++; if (tx !== v[0]) begin errors++; $display("FAIL data_bit0: got %b expected %b", tx, v[0]); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", tx); end
    bus_read(A_ST, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL midreset_status: got %h expected 00000004", d); end
    bus_read(A_DIV, d);
    checks++; if (d !== 32'd433) begin errors++; $display("FAIL midreset_div: got %0d expected 433", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    reset = 1'b1;
    m_div = 16'd433; m_ctrl = 2'b01;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_frames();
    test_overflow();
    test_lanes_decode();
    test_irq_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
